// File: rtl/final_project_pulse_pio.sv
// Avalon-MM PIO output port with DATA/SET/CLEAR registers and a self-timed
// pulse overlay (MASK held on out_port for PULSE_LEN cycles).
//
// state | meaning
// IDLE  | no pulse active, COUNT held at 0, MASK cleared
// BUSY  | pulse active, MASK ORed onto out_port, COUNT counting down to 1
module final_project_pulse_pio #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PULSE_LEN   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [15:0] PULSE_CNT = 16'(PULSE_LEN);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data, data_nx;
    logic [WIDTH-1:0] mask, mask_nx;
    logic [15:0]      count, count_nx;
    logic             done, done_nx;

    logic             wr;
    logic [WIDTH-1:0] wmask;

    assign wr    = chipselect && !write_n;
    assign wmask = writedata[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            data  <= RESET_VALUE;
            mask  <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            data  <= data_nx;
            mask  <= mask_nx;
            count <= count_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        data_nx  = data;
        mask_nx  = mask;
        count_nx = count;
        done_nx  = done;

        if (state == BUSY) begin
            if (count == 16'd1) begin
                count_nx = '0;
                mask_nx  = '0;
                state_nx = IDLE;
                done_nx  = 1'b1;
            end else begin
                count_nx = count - 16'd1;
            end
        end

        // A write to PULSE overrides the countdown step above, so a retrigger
        // on the final BUSY cycle reloads instead of expiring.
        if (wr) begin
            case (address)
                2'd0: data_nx = wmask;
                2'd1: data_nx = data | wmask;
                2'd2: data_nx = data & ~wmask;
                2'd3: begin
                    done_nx = 1'b0;
                    if (|wmask) begin
                        mask_nx  = wmask;
                        count_nx = PULSE_CNT;
                        state_nx = BUSY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_port = data | ((state == BUSY) ? mask : '0);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = data;
            2'd3:    readdata = {(state == BUSY), done, 14'b0, count};
            default: readdata = '0;
        endcase
    end

endmodule
